pipe_hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage advanced pipelined CPU.
- Sequences the IF/ID, ID/EX and EX/MEM pipe registers and the PC by generating their keep (stall) and flush controls.
- Covers three hazard sources:
  - load-use data hazards,
  - taken branches resolved in MEM,
  - multi-cycle EX operations (MUL/DIV), which freeze the front end for a programmable number of cycles.
- Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/hazard_stall_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encoding,
// register-index width and the hard-wired zero register index.
package cpu_pkg;

  localparam int REG_W = 5;

  // Pipeline control FSM states
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  // Register 0 is hard-wired to zero, so writes to it never create a hazard
  localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_stall_counter.sv
// Saturating event counter with enable. Counts up by one per enabled cycle,
// sticks at all-ones and is cleared only by reset.
module hazard_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_reg;

  // Count enabled cycles, holding at the maximum value instead of wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (en_i && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit for the 5-stage CPU. Generates keep/flush controls
// for the IF/ID, ID/EX and EX/MEM registers and the PC write enable from
// load-use hazards, taken branches resolved in MEM and multi-cycle EX ops.
// Control outputs are combinational so they act in the current cycle.
module pipe_hazard_ctrl #(
  parameter int REG_W   = cpu_pkg::REG_W,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ID_rs_i,
  input  logic [REG_W-1:0] ID_rt_i,
  input  logic             EX_MemRead_i,
  input  logic [REG_W-1:0] EX_rt_i,
  input  logic             EX_MulStart_i,
  input  logic             MEM_BranchTaken_i,
  output logic             PC_Write_o,
  output logic             IF_Keep_o,
  output logic             IF_Flush_o,
  output logic             ID_Keep_o,
  output logic             ID_Flush_o,
  output logic             EX_Keep_o,
  output logic             EX_Flush_o,
  output logic             Busy_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  import cpu_pkg::state_e;
  import cpu_pkg::ST_RUN;
  import cpu_pkg::ST_MUL_BUSY;
  import cpu_pkg::REG_ZERO;

  localparam int BW = $clog2(MUL_LAT);

  state_e        state_reg, state_next;
  logic [BW-1:0] busy_cnt_reg, busy_cnt_next;
  logic          load_use;

  // A load in EX whose destination feeds the instruction in ID
  assign load_use = EX_MemRead_i && (EX_rt_i != REG_W'(REG_ZERO)) &&
                    ((EX_rt_i == ID_rs_i) || (EX_rt_i == ID_rt_i));

  // State and multi-cycle down-counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_RUN;
      busy_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  // Next-state and pipeline controls; branch squash outranks every stall
  always_comb begin
    state_next    = state_reg;
    busy_cnt_next = busy_cnt_reg;
    PC_Write_o    = 1'b1;
    IF_Keep_o     = 1'b0;
    IF_Flush_o    = 1'b0;
    ID_Keep_o     = 1'b0;
    ID_Flush_o    = 1'b0;
    EX_Keep_o     = 1'b0;
    EX_Flush_o    = 1'b0;
    Busy_o        = (state_reg == ST_MUL_BUSY);

    unique case (state_reg)
      ST_RUN: begin
        if (MEM_BranchTaken_i) begin
          // Younger instructions are wrong-path: drop them, PC takes target
          IF_Flush_o = 1'b1;
          ID_Flush_o = 1'b1;
          EX_Flush_o = 1'b1;
        end else if (EX_MulStart_i) begin
          PC_Write_o    = 1'b0;
          IF_Keep_o     = 1'b1;
          ID_Keep_o     = 1'b1;
          EX_Flush_o    = 1'b1;
          state_next    = ST_MUL_BUSY;
          busy_cnt_next = BW'(MUL_LAT - 2);
        end else if (load_use) begin
          // One bubble; next cycle the load sits in MEM and can forward
          PC_Write_o = 1'b0;
          IF_Keep_o  = 1'b1;
          ID_Flush_o = 1'b1;
        end
      end

      ST_MUL_BUSY: begin
        if (MEM_BranchTaken_i) begin
          // The branch is older than the mul, so the mul is squashed too
          IF_Flush_o    = 1'b1;
          ID_Flush_o    = 1'b1;
          EX_Flush_o    = 1'b1;
          state_next    = ST_RUN;
          busy_cnt_next = '0;
        end else begin
          PC_Write_o = 1'b0;
          IF_Keep_o  = 1'b1;
          ID_Keep_o  = 1'b1;
          EX_Flush_o = 1'b1;
          if (busy_cnt_reg == '0) begin
            state_next = ST_RUN;
          end else begin
            busy_cnt_next = busy_cnt_reg - 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Every cycle the PC is held counts as a stall
  hazard_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!PC_Write_o),
    .cnt_o (StallCnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
// u_dut (CNT_W=16) for functional checks, u_sat (CNT_W=2) for saturation.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;

  // Control vector: {PC_Write, IF_Keep, IF_Flush, ID_Keep, ID_Flush,
  //                  EX_Keep, EX_Flush, Busy}
  localparam logic [7:0] C_IDLE = 8'b1000_0000;
  localparam logic [7:0] C_LU   = 8'b0100_1000;
  localparam logic [7:0] C_BR   = 8'b1010_1010;
  localparam logic [7:0] C_MS   = 8'b0101_0010;
  localparam logic [7:0] C_MB   = 8'b0101_0011;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [REG_W-1:0] ID_rs_i, ID_rt_i, EX_rt_i;
  logic             EX_MemRead_i, EX_MulStart_i, MEM_BranchTaken_i;

  logic a_pc, a_ifk, a_iff, a_idk, a_idf, a_exk, a_exf, a_busy;
  logic b_pc, b_ifk, b_iff, b_idk, b_idf, b_exk, b_exf, b_busy;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;
  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign ctl = {a_pc, a_ifk, a_iff, a_idk, a_idf, a_exk, a_exf, a_busy};

  pipe_hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(4), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_rt_i(EX_rt_i),
    .EX_MulStart_i(EX_MulStart_i), .MEM_BranchTaken_i(MEM_BranchTaken_i),
    .PC_Write_o(a_pc), .IF_Keep_o(a_ifk), .IF_Flush_o(a_iff),
    .ID_Keep_o(a_idk), .ID_Flush_o(a_idf), .EX_Keep_o(a_exk),
    .EX_Flush_o(a_exf), .Busy_o(a_busy), .StallCnt_o(a_cnt)
  );

  pipe_hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(4), .CNT_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_rt_i(EX_rt_i),
    .EX_MulStart_i(EX_MulStart_i), .MEM_BranchTaken_i(MEM_BranchTaken_i),
    .PC_Write_o(b_pc), .IF_Keep_o(b_ifk), .IF_Flush_o(b_iff),
    .ID_Keep_o(b_idk), .ID_Flush_o(b_idf), .EX_Keep_o(b_exk),
    .EX_Flush_o(b_exf), .Busy_o(b_busy), .StallCnt_o(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ID_rs_i = '0; ID_rt_i = '0; EX_rt_i = '0;
    EX_MemRead_i = 1'b0; EX_MulStart_i = 1'b0; MEM_BranchTaken_i = 1'b0;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic [REG_W-1:0] ex_rt);
    ID_rs_i = rs; ID_rt_i = rt; EX_rt_i = ex_rt; EX_MemRead_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_cnt", 32'(a_cnt), 32'd0);

    // 1. Load-use on rs, then on rt
    set_lu(5'd5, 5'd9, 5'd5);
    #1 chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    tick(); idle();
    #1 chk("lu_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("lu_after_cnt", 32'(a_cnt), 32'd1);
    set_lu(5'd3, 5'd7, 5'd7);
    #1 chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    tick(); idle();
    #1 chk("lu_rt_cnt", 32'(a_cnt), 32'd2);

    // Non-matching load: no stall
    set_lu(5'd1, 5'd2, 5'd3);
    #1 chk("lu_nomatch_ctl", 32'(ctl), 32'(C_IDLE));
    tick(); idle();

    // 2. Zero-register exclusion
    set_lu(5'd0, 5'd0, 5'd0);
    #1 chk("zero_ctl", 32'(ctl), 32'(C_IDLE));
    tick(); idle();
    #1 chk("zero_cnt", 32'(a_cnt), 32'd2);

    // 3. Branch beats load-use
    set_lu(5'd5, 5'd0, 5'd5);
    MEM_BranchTaken_i = 1'b1;
    #1 chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
    tick(); idle();
    #1 chk("br_lu_cnt", 32'(a_cnt), 32'd2);

    // Branch beats a mul start
    EX_MulStart_i = 1'b1; MEM_BranchTaken_i = 1'b1;
    #1 chk("br_ms_ctl", 32'(ctl), 32'(C_BR));
    tick(); idle();
    #1 chk("br_ms_state", 32'(ctl), 32'(C_IDLE));

    // 4. Multi-cycle op: start cycle + 3 busy cycles, then RUN
    EX_MulStart_i = 1'b1;
    #1 chk("mul_start_ctl", 32'(ctl), 32'(C_MS));
    tick(); EX_MulStart_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // load-use is ignored while busy
      set_lu(5'd4, 5'd0, 5'd4);
      #1 chk($sformatf("mul_busy%0d_ctl", i), 32'(ctl), 32'(C_MB));
      tick(); idle();
    end
    #1 chk("mul_done_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mul_done_cnt", 32'(a_cnt), 32'd6);

    // 5. Branch on 2nd busy cycle squashes the mul
    EX_MulStart_i = 1'b1;
    tick(); EX_MulStart_i = 1'b0;
    #1 chk("mbr_busy1_ctl", 32'(ctl), 32'(C_MB));
    tick();
    MEM_BranchTaken_i = 1'b1;
    #1 chk("mbr_flush_ctl", 32'(ctl[7:1]), 32'(C_BR[7:1]));
    tick(); idle();
    #1 chk("mbr_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mbr_after_cnt", 32'(a_cnt), 32'd8);

    // 6. Reset during MUL_BUSY aborts the op and clears the counters
    EX_MulStart_i = 1'b1;
    tick(); EX_MulStart_i = 1'b0;
    #1 chk("rst_busy_ctl", 32'(ctl), 32'(C_MB));
    rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    #1 chk("rst_mid_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_mid_cnt", 32'(a_cnt), 32'd0);
    chk("rst_mid_satcnt", 32'(b_cnt), 32'd0);

    // Saturation with CNT_W=2: five stalled cycles stop at 3
    set_lu(5'd6, 5'd0, 5'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat_cnt%0d", i + 1), 32'(b_cnt), (i < 3) ? i + 1 : 3);
    end
    chk("sat_wide_cnt", 32'(a_cnt), 32'd5);
    idle();
    tick();
    chk("sat_hold_cnt", 32'(b_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always ends on its own
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
